// File: rtl/textlcd_pkg.sv
// Shared constants, FSM state type and address helpers for the text-LCD bus decoder.
package textlcd_pkg;

    // Instruction opcodes; the class of an instruction is its highest set bit
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPCTL = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNCSET = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    localparam int         LINE_LEN   = 40;
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);
    localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);

    typedef enum logic {
        S_UNINIT = 1'b0,
        S_READY  = 1'b1
    } dec_state_t;

    // Address lies inside one of the two 40-cell line windows
    function automatic logic ac_legal(input logic [6:0] a);
        return (a <= LINE1_LAST) || ((a >= LINE2_BASE) && (a <= LINE2_LAST));
    endfunction

    // Address counter step, wrapping between the two line windows
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE1_LAST) return LINE2_BASE;
            if (a == LINE2_LAST) return LINE1_BASE;
            return a + 7'd1;
        end
        if (a == LINE1_BASE) return LINE2_LAST;
        if (a == LINE2_BASE) return LINE1_LAST;
        return a - 7'd1;
    endfunction

    // Flat cell index 0..79 from line and column
    function automatic logic [6:0] cell_index(input logic line, input logic [5:0] col);
        return line ? (7'(LINE_LEN) + {1'b0, col}) : {1'b0, col};
    endfunction

    // Display offset arithmetic, modulo the line length
    function automatic logic [5:0] ofs_inc(input logic [5:0] o);
        return (o == 6'(LINE_LEN - 1)) ? 6'd0 : o + 6'd1;
    endfunction

    function automatic logic [5:0] ofs_dec(input logic [5:0] o);
        return (o == 6'd0) ? 6'(LINE_LEN - 1) : o - 6'd1;
    endfunction

endpackage

// File: rtl/textlcd_bus_sync.sv
// Synchronizer for the LCD bus pins plus falling-edge strobe on E.
// A strobe needs E seen low, then high, then low again after reset, so a
// pulse already in progress when reset releases is never decoded.
module textlcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_e,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [7:0] i_data,
    output logic       o_strobe,
    output logic       o_rs,
    output logic       o_rw,
    output logic [7:0] o_data
);

    logic [10:0]            r_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_armed;
    logic                   r_high;
    logic                   w_e;
    logic                   w_valid;

    assign w_e      = r_sync[SYNC_STAGES-1][10];
    assign w_valid  = r_fill[SYNC_STAGES-1];
    assign o_rs     = r_sync[SYNC_STAGES-1][9];
    assign o_rw     = r_sync[SYNC_STAGES-1][8];
    assign o_data   = r_sync[SYNC_STAGES-1][7:0];
    assign o_strobe = r_high & ~w_e;

    // Sync chain; r_fill marks when the last stage holds a post-reset sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_fill <= '0;
        end else begin
            r_sync[0] <= {i_e, i_rs, i_rw, i_data};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge qualification: armed by a real low, then a high, then strobe on the fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed <= 1'b0;
            r_high  <= 1'b0;
        end else begin
            if (w_valid && !w_e) r_armed <= 1'b1;
            if (o_strobe)                r_high <= 1'b0;
            else if (r_armed && w_e)     r_high <= 1'b1;
        end
    end

endmodule

// File: rtl/textlcd_bus_decoder.sv
// HD44780-style bus responder: decodes instructions and character writes
// seen on the LCD pins and mirrors the 2x40 DDRAM image.
// Optional display shift support: define TEXTLCD_DEC_SHIFT_EN.
//
//   state    | meaning
//   S_UNINIT | waiting for function set with DL=1
//   S_READY  | normal instruction and data decode
module textlcd_bus_decoder
    import textlcd_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] BLANK_CHAR   = 8'h20,
    parameter bit         REQUIRE_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic       rd_line,
    input  logic [5:0] rd_col,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       init_done,
    output logic       wr_pulse,
    output logic       cmd_err
);

    logic       w_stb, w_rs, w_rw;
    logic [7:0] w_data;

    dec_state_t r_state, w_state_next;
    logic [6:0] r_ac, w_ac_next;
    logic       r_id, w_id_next;
    logic [2:0] r_dcb, w_dcb_next;
    logic       r_init, w_init_next;
    logic       r_wr_pulse, r_cmd_err;
    logic       w_wr, w_err, w_clear, w_decode_en;
    logic [79:0] r_valid;
    logic [7:0] r_cell [0:79];
    logic [7:0] r_rd_char;
    logic [6:0] w_wr_idx, w_rd_idx;
    logic [5:0] w_rd_cell_col;
`ifdef TEXTLCD_DEC_SHIFT_EN
    logic [5:0] r_ofs, w_ofs_next;
    logic       r_s, w_s_next;
    logic [6:0] w_rd_sum;
`endif

    textlcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_e      (lcd_e),
        .i_rs     (lcd_rs),
        .i_rw     (lcd_rw),
        .i_data   (lcd_data),
        .o_strobe (w_stb),
        .o_rs     (w_rs),
        .o_rw     (w_rw),
        .o_data   (w_data)
    );

    assign w_decode_en = (r_state == S_READY) || !REQUIRE_INIT;
    assign w_wr_idx    = cell_index(r_ac[6], r_ac[5:0]);

    // Next-state and decode of one strobe
    always_comb begin
        w_state_next = r_state;
        w_ac_next    = r_ac;
        w_id_next    = r_id;
        w_dcb_next   = r_dcb;
        w_init_next  = r_init;
        w_wr         = 1'b0;
        w_err        = 1'b0;
        w_clear      = 1'b0;
`ifdef TEXTLCD_DEC_SHIFT_EN
        w_ofs_next   = r_ofs;
        w_s_next     = r_s;
`endif
        if (w_stb && !w_rw) begin
            if (w_rs) begin
                if (w_decode_en) begin
                    w_wr      = 1'b1;
                    w_ac_next = ac_step(r_ac, r_id);
`ifdef TEXTLCD_DEC_SHIFT_EN
                    if (r_s) w_ofs_next = r_id ? ofs_dec(r_ofs) : ofs_inc(r_ofs);
`endif
                end else begin
                    w_err = 1'b1;
                end
            end else if ((w_data >= OP_FUNCSET) && (w_data < OP_CGRAM)) begin
                if (!w_data[4]) begin
                    w_err = 1'b1;
                end else if (r_state == S_UNINIT) begin
                    w_state_next = S_READY;
                    w_init_next  = 1'b1;
                end
            end else if (!w_decode_en) begin
                w_err = 1'b1;
            end else if (w_data >= OP_DDRAM) begin
                if (ac_legal(w_data[6:0])) w_ac_next = w_data[6:0];
                else                       w_err     = 1'b1;
            end else if (w_data >= OP_CGRAM) begin
                w_err = 1'b1;
            end else if (w_data >= OP_SHIFT) begin
`ifdef TEXTLCD_DEC_SHIFT_EN
                if (w_data[3]) w_ofs_next = w_data[2] ? ofs_dec(r_ofs) : ofs_inc(r_ofs);
                else           w_ac_next  = ac_step(r_ac, w_data[2]);
`endif
            end else if (w_data >= OP_DISPCTL) begin
                w_dcb_next = w_data[2:0];
            end else if (w_data >= OP_ENTRY) begin
                w_id_next = w_data[1];
`ifdef TEXTLCD_DEC_SHIFT_EN
                w_s_next  = w_data[0];
`endif
            end else if (w_data >= OP_HOME) begin
                w_ac_next = LINE1_BASE;
`ifdef TEXTLCD_DEC_SHIFT_EN
                w_ofs_next = 6'd0;
`endif
            end else if (w_data >= OP_CLEAR) begin
                w_clear   = 1'b1;
                w_ac_next = LINE1_BASE;
                w_id_next = 1'b1;
`ifdef TEXTLCD_DEC_SHIFT_EN
                w_ofs_next = 6'd0;
`endif
            end else begin
                w_err = 1'b1;
            end
        end
    end

    // State register, control registers, valid bits and pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_UNINIT;
            r_ac       <= '0;
            r_id       <= 1'b1;
            r_dcb      <= '0;
            r_init     <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_valid    <= '0;
`ifdef TEXTLCD_DEC_SHIFT_EN
            r_ofs      <= '0;
            r_s        <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_ac       <= w_ac_next;
            r_id       <= w_id_next;
            r_dcb      <= w_dcb_next;
            r_init     <= w_init_next;
            r_wr_pulse <= w_wr;
            r_cmd_err  <= w_err;
            if (w_clear)   r_valid           <= '0;
            else if (w_wr) r_valid[w_wr_idx] <= 1'b1;
`ifdef TEXTLCD_DEC_SHIFT_EN
            r_ofs      <= w_ofs_next;
            r_s        <= w_s_next;
`endif
        end
    end

    // Cell storage; contents only matter where the valid bit is set
    always_ff @(posedge clk) begin
        if (w_wr) r_cell[w_wr_idx] <= w_data;
    end

`ifdef TEXTLCD_DEC_SHIFT_EN
    assign w_rd_sum      = {1'b0, rd_col} + {1'b0, r_ofs};
    assign w_rd_cell_col = (w_rd_sum >= 7'(LINE_LEN)) ? 6'(w_rd_sum - 7'(LINE_LEN)) : w_rd_sum[5:0];
`else
    assign w_rd_cell_col = rd_col;
`endif
    assign w_rd_idx = cell_index(rd_line, w_rd_cell_col);

    // Registered read port, independent of decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                r_rd_char <= '0;
        else if (rd_col > 6'(LINE_LEN - 1))      r_rd_char <= BLANK_CHAR;
        else if (r_valid[w_rd_idx])              r_rd_char <= r_cell[w_rd_idx];
        else                                     r_rd_char <= BLANK_CHAR;
    end

    assign rd_char   = r_rd_char;
    assign ac        = r_ac;
    assign disp_on   = r_dcb[2];
    assign cursor_on = r_dcb[1];
    assign blink_on  = r_dcb[0];
    assign init_done = r_init;
    assign wr_pulse  = r_wr_pulse;
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_textlcd_bus_decoder.sv
// Scoreboard bench for textlcd_bus_decoder: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT shows a pulse or a probe is raised.
module tb_textlcd_bus_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic       rd_line = 1'b0;
    logic [5:0] rd_col = 6'd0;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, init_done, wr_pulse, cmd_err;

    textlcd_bus_decoder dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_line(rd_line), .rd_col(rd_col), .rd_char(rd_char),
        .ac(ac), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .init_done(init_done), .wr_pulse(wr_pulse), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef enum int {K_WR, K_ERR, K_RD, K_AC, K_STAT} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  probe = 1'b0;
    kind_e probe_k = K_RD;

    task automatic score(input kind_e k, input logic [7:0] act);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_%s: actual %02h, required no event", k.name(), act);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val !== act) begin
                n_errors++;
                $display("FAIL %s: actual %s=%02h, required %s=%02h",
                         e.name, k.name(), act, e.kind.name(), e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (wr_pulse) score(K_WR, 8'h00);
        if (cmd_err)  score(K_ERR, 8'h00);
        if (probe) begin
            case (probe_k)
                K_RD:    score(K_RD, rd_char);
                K_AC:    score(K_AC, {1'b0, ac});
                K_STAT:  score(K_STAT, {4'b0000, init_done, disp_on, cursor_on, blink_on});
                default: score(probe_k, 8'h00);
            endcase
        end
    end

    task automatic expect_ev(input kind_e k, input logic [7:0] v, input string n);
        exp_t e;
        e.kind = k; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    // One bus transfer as the writer would drive it
    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; lcd_data = d;
        @(posedge clk); #1 lcd_e = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic cmd(input logic [7:0] d, input bit err, input string n);
        if (err) expect_ev(K_ERR, 8'h00, n);
        xfer(1'b0, 1'b0, d);
    endtask

    task automatic dat(input logic [7:0] d, input bit ok, input string n);
        expect_ev(ok ? K_WR : K_ERR, 8'h00, n);
        xfer(1'b1, 1'b0, d);
    endtask

    task automatic do_probe(input kind_e k, input logic [7:0] v, input string n);
        expect_ev(k, v, n);
        @(posedge clk); #1;
        probe_k = k; probe = 1'b1;
        @(posedge clk); #1 probe = 1'b0;
    endtask

    task automatic rd(input logic line, input logic [5:0] col, input logic [7:0] v, input string n);
        @(posedge clk); #1;
        rd_line = line; rd_col = col;
        do_probe(K_RD, v, n);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) dat(s[i], 1'b1, "wr_pulse");
    endtask

    task automatic chk_str(input logic line, input string s, input string n);
        for (int i = 0; i < s.len(); i++) rd(line, 6'(i), s[i], n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: reset state and writes before init
        do_probe(K_AC, 8'h00, "reset_ac");
        do_probe(K_STAT, 8'h00, "reset_status");
        dat("A", 1'b0, "write_before_init_err");
        cmd(8'h20, 1'b1, "funcset_dl0_err");
        rd(1'b0, 6'd0, 8'h20, "rd_blank_before_init");
        do_probe(K_STAT, 8'h00, "still_uninit");

        // 2: init and a short string
        cmd(8'h3C, 1'b0, "");
        cmd(8'h0C, 1'b0, "");
        cmd(8'h06, 1'b0, "");
        cmd(8'h80, 1'b0, "");
        send_str("MODE :");
        chk_str(1'b0, "MODE :", "rd_mode");
        do_probe(K_AC, 8'h06, "ac_after_mode");
        do_probe(K_STAT, 8'h0C, "status_disp_on");
        rd(1'b0, 6'd40, 8'h20, "rd_col40_blank");
        rd(1'b0, 6'd63, 8'h20, "rd_col63_blank");

        // 3: line wrap on increment, then decrement wrap 0x00 -> 0x67
        cmd(8'hA7, 1'b0, "");
        dat("X", 1'b1, "wr_X");
        dat("Y", 1'b1, "wr_Y");
        rd(1'b0, 6'd39, "X", "rd_cell27");
        rd(1'b1, 6'd0, "Y", "rd_cell40");
        do_probe(K_AC, 8'h41, "ac_after_wrap_inc");
        cmd(8'h04, 1'b0, "");
        cmd(8'h80, 1'b0, "");
        dat("Z", 1'b1, "wr_Z");
        rd(1'b0, 6'd0, "Z", "rd_cell00");
        do_probe(K_AC, 8'h67, "ac_after_wrap_dec");

        // 4: illegal addresses, repeated clears, second line
        cmd(8'hA8, 1'b1, "ddram_28_err");
        do_probe(K_AC, 8'h67, "ac_kept_after_bad_addr");
        cmd(8'h40, 1'b1, "cgram_err");
        for (int i = 0; i < 200; i++) cmd(8'h01, 1'b0, "");
        do_probe(K_AC, 8'h00, "ac_after_clears");
        cmd(8'hC0, 1'b0, "");
        send_str("WATCH");
        for (int c = 0; c < 40; c++) rd(1'b0, 6'(c), 8'h20, "line1_cleared");
        chk_str(1'b1, "WATCH", "rd_watch");
        rd(1'b1, 6'd5, 8'h20, "line2_col5_blank");
        do_probe(K_AC, 8'h45, "ac_after_watch");
        cmd(8'h0F, 1'b0, "");
        do_probe(K_STAT, 8'h0F, "status_dcb_all");

        // 5: reads on the bus are ignored; reset in the middle of an E pulse
        xfer(1'b0, 1'b1, 8'h00);
        xfer(1'b1, 1'b1, 8'h41);
        do_probe(K_AC, 8'h45, "ac_after_rw_reads");
        do_probe(K_STAT, 8'h0F, "status_after_rw_reads");
        rd(1'b1, 6'd0, "W", "cell_after_rw_reads");
        @(posedge clk); #1;
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = "Q"; lcd_e = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        do_probe(K_AC, 8'h00, "ac_in_reset");
        do_probe(K_STAT, 8'h00, "status_in_reset");
        rd(1'b1, 6'd0, 8'h00, "rd_char_in_reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (6) @(posedge clk);
        dat("Q", 1'b0, "first_full_edge_err");
        rd(1'b1, 6'd0, 8'h20, "cell_invalid_after_reset");

        // 6: shift instruction
        cmd(8'h38, 1'b0, "");
        cmd(8'h06, 1'b0, "");
        cmd(8'h80, 1'b0, "");
        send_str("ABC");
        cmd(8'h18, 1'b0, "shift_no_err");
        do_probe(K_AC, 8'h03, "ac_after_shift");
`ifdef TEXTLCD_DEC_SHIFT_EN
        rd(1'b0, 6'd0, "B", "shifted_col0");
        rd(1'b0, 6'd1, "C", "shifted_col1");
        rd(1'b0, 6'd2, 8'h20, "shifted_col2");
`else
        rd(1'b0, 6'd0, "A", "unshifted_col0");
`endif
        cmd(8'h02, 1'b0, "");
        rd(1'b0, 6'd0, "A", "home_col0");
        do_probe(K_AC, 8'h00, "ac_after_home");

        repeat (20) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL missing_events: actual %0d pending, required 0 (next: %s)",
                     sb.size(), sb[0].name);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
